mipsfpga_ahb_sevensegarb: RTL and testbench

Two-requester arbiter that shares the Nexys4-DDR eight-digit seven-segment display between independent content sources, e.g. the AHB-mapped CPU register and a hardware status/debug source. It sits directly in front of the seven-segment display timer and drives that timer's digit-enable and digit-value inputs. Ownership uses a request/grant handshake with round-robin fairness and a bounded tenure. A long-running owner is preempted when the other source is waiting. Outputs are registered so the display never shows a mix of two sources.

---
 rtl/mipsfpga_ahb_sevensegarb.sv | 116 +++++++++++
 tb/tb_mipsfpga_ahb_sevensegarb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mipsfpga_ahb_sevensegarb.sv
// Two-requester arbiter for the eight-digit seven-segment display.
// Round-robin ownership with a bounded tenure under contention. The
// digit enables and values are registered, so the display only ever
// shows one source's data at a time.
module mipsfpga_ahb_sevensegarb #(
    parameter int MAX_HOLD = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  en0,
    input  logic [31:0] disp0,
    input  logic [7:0]  en1,
    input  logic [31:0] disp1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  EN,
    output logic [31:0] DISP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(MAX_HOLD - 1);

    state_t      state;
    state_t      state_next;
    logic        last;
    logic [15:0] cnt;
    logic        hold_done;

    assign hold_done = (cnt == CNT_MAX);
    assign gnt0      = (state == OWN0);
    assign gnt1      = (state == OWN1);

    // Next-state selection: round-robin on a tie, every release or preemption goes via IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_next = last ? OWN0 : OWN1;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!req0 || (req1 && hold_done))
                    state_next = IDLE;
            end
            OWN1: begin
                if (!req1 || (req0 && hold_done))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Round-robin pointer remembers who was granted most recently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= 1'b1;
        else if (state == IDLE && state_next == OWN0)
            last <= 1'b0;
        else if (state == IDLE && state_next == OWN1)
            last <= 1'b1;
    end

    // Tenure counter: held at zero in IDLE (so every grant starts from zero),
    // counts while owned and sticks at MAX_HOLD-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= 16'd0;
        else if (state == IDLE)
            cnt <= 16'd0;
        else if (!hold_done)
            cnt <= cnt + 16'd1;
    end

    // Display registers follow the current owner, blank when nobody owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EN   <= 8'hff;
            DISP <= 32'h0;
        end else begin
            case (state)
                OWN0: begin
                    EN   <= en0;
                    DISP <= disp0;
                end
                OWN1: begin
                    EN   <= en1;
                    DISP <= disp1;
                end
                default: begin
                    EN   <= 8'hff;
                    DISP <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipsfpga_ahb_sevensegarb.sv
// Scoreboard bench for the seven-segment arbiter: the driver issues one
// input vector per cycle and pushes the outputs a cycle-level ownership
// model predicts; a monitor pops and compares after every rising edge.
module tb_mipsfpga_ahb_sevensegarb;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  en0, en1;
    logic [31:0] disp0, disp1;
    logic        gnt0, gnt1;
    logic [7:0]  EN;
    logic [31:0] DISP;

    mipsfpga_ahb_sevensegarb #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .en0   (en0),
        .disp0 (disp0),
        .en1   (en1),
        .disp1 (disp1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .EN    (EN),
        .DISP  (DISP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        g0;
        logic        g1;
        logic [7:0]  en;
        logic [31:0] disp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the display (-1 = nobody), how long, who won last.
    int m_owner;
    int m_ten;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ten   = 0;
        m_last  = 1;
    endtask

    // One rising edge of the model; pushes the outputs expected right after it.
    task automatic model_step(input logic r0, input logic r1,
                              input logic [7:0] e0, input logic [31:0] d0,
                              input logic [7:0] e1, input logic [31:0] d1);
        exp_t e;
        int mine, other;
        // the display shows whoever owned it during the cycle that is ending
        if (m_owner == 0) begin
            e.en = e0; e.disp = d0;
        end else if (m_owner == 1) begin
            e.en = e1; e.disp = d1;
        end else begin
            e.en = 8'hff; e.disp = 32'h0;
        end
        if (m_owner < 0) begin
            int pick;
            pick = -1;
            if (r0 && r1) pick = 1 - m_last;
            else if (r0)  pick = 0;
            else if (r1)  pick = 1;
            if (pick >= 0) begin
                m_owner = pick;
                m_last  = pick;
                m_ten   = 0;
            end
        end else begin
            mine  = (m_owner == 0) ? int'(r0) : int'(r1);
            other = (m_owner == 0) ? int'(r1) : int'(r0);
            if (mine == 0 || (other != 0 && m_ten == MAX_HOLD - 1))
                m_owner = -1;
            else if (m_ten < MAX_HOLD - 1)
                m_ten++;
        end
        e.g0 = (m_owner == 0);
        e.g1 = (m_owner == 1);
        q.push_back(e);
    endtask

    task automatic cycle(input logic r0, input logic r1,
                         input logic [7:0] e0, input logic [31:0] d0,
                         input logic [7:0] e1, input logic [31:0] d1);
        @(negedge clk);
        req0 = r0; req1 = r1;
        en0 = e0; disp0 = d0;
        en1 = e1; disp1 = d1;
        model_step(r0, r1, e0, d0, e1, d1);
    endtask

    task automatic rcycle(input logic r0, input logic r1);
        cycle(r0, r1, 8'($urandom), $urandom, 8'($urandom), $urandom);
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt0", 32'(gnt0), 32'(e.g0));
                chk("gnt1", 32'(gnt1), 32'(e.g1));
                chk("EN", 32'(EN), 32'(e.en));
                chk("DISP", DISP, e.disp);
                chk("exclusive_grant", 32'(gnt0 & gnt1), 32'd0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        req0 = 0; req1 = 0;
        en0 = 8'h00; en1 = 8'h00; disp0 = 32'h0; disp1 = 32'h0;
        model_reset();
        #12;
        chk("reset_gnt0", 32'(gnt0), 32'd0);
        chk("reset_gnt1", 32'(gnt1), 32'd0);
        chk("reset_EN", 32'(EN), 32'hff);
        chk("reset_DISP", DISP, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // single requester with fixed data, then release
        repeat (3) cycle(1, 0, 8'hf0, 32'h76543210, 8'h0f, 32'h11111111);
        repeat (3) cycle(0, 0, 8'hf0, 32'h76543210, 8'h0f, 32'h11111111);

        // continuous contention: 4-cycle tenures alternating with one idle cycle
        repeat (20) rcycle(1, 1);
        repeat (2) rcycle(0, 0);

        // no contention: tenure never ends, then req1 preempts
        repeat (20) rcycle(1, 0);
        repeat (4) rcycle(1, 1);
        repeat (2) rcycle(0, 0);

        // data passthrough while requester 1 owns the display
        repeat (3) cycle(0, 1, 8'($urandom), $urandom, 8'h00, 32'h0);
        repeat (3) cycle(0, 1, 8'($urandom), $urandom, 8'h00, 32'hdeadbeef);
        repeat (2) rcycle(0, 0);

        // release on the very edge preemption would fire
        n = 0;
        while (!(m_owner == 0 && m_ten == MAX_HOLD - 1) && n < 30) begin
            rcycle(1, 1);
            n++;
        end
        chk("reach_preempt_point", 32'(n < 30), 32'd1);
        repeat (4) rcycle(0, 1);
        repeat (2) rcycle(0, 0);

        // randomized traffic
        repeat (400) rcycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0));

        // asynchronous reset in the middle of a requester-1 tenure
        repeat (2) rcycle(0, 0);
        n = 0;
        while (m_owner != 1 && n < 5) begin
            rcycle(0, 1);
            n++;
        end
        rcycle(0, 1);
        @(negedge clk);
        #2;
        chk("pre_reset_gnt1", 32'(gnt1), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_gnt0", 32'(gnt0), 32'd0);
        chk("async_reset_gnt1", 32'(gnt1), 32'd0);
        chk("async_reset_EN", 32'(EN), 32'hff);
        chk("async_reset_DISP", DISP, 32'h0);
        model_reset();
        req0 = 0; req1 = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // after reset a tie goes to requester 0
        rcycle(1, 1);
        @(posedge clk);
        #2;
        chk("tie_after_reset_gnt0", 32'(gnt0), 32'd1);
        repeat (10) rcycle(1, 1);
        repeat (3) rcycle(0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
